// File: rtl/vga_canvas_pkg.sv
// Shared timing defaults, canvas FSM state type and palette for the VGA drawing canvas.
package vga_canvas_pkg;

    localparam int H_SYNC_DEF = 128;
    localparam int H_BP_DEF   = 88;
    localparam int H_ACT_DEF  = 800;
    localparam int H_FP_DEF   = 40;
    localparam int V_SYNC_DEF = 4;
    localparam int V_BP_DEF   = 23;
    localparam int V_ACT_DEF  = 600;
    localparam int V_FP_DEF   = 1;

    localparam int H_LINE      = H_SYNC_DEF + H_BP_DEF + H_ACT_DEF + H_FP_DEF;
    localparam int V_FRAME     = V_SYNC_DEF + V_BP_DEF + V_ACT_DEF + V_FP_DEF;
    localparam int H_ACT_START = H_SYNC_DEF + H_BP_DEF;
    localparam int H_ACT_END   = H_ACT_START + H_ACT_DEF;
    localparam int V_ACT_START = V_SYNC_DEF + V_BP_DEF;
    localparam int V_ACT_END   = V_ACT_START + V_ACT_DEF;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_PAINT = 2'd1,
        ST_ERASE = 2'd2,
        ST_CLEAR = 2'd3
    } canvas_state_e;

    typedef struct packed {
        logic [3:0] r;
        logic [3:0] g;
        logic [3:0] b;
    } rgb_t;

    localparam rgb_t C_BLANK   = 12'h222;
    localparam rgb_t C_GREEN   = 12'h0F0;
    localparam rgb_t C_BLUE    = 12'h00F;
    localparam rgb_t C_YELLOW  = 12'hFF0;
    localparam rgb_t C_RED     = 12'hF00;
    localparam rgb_t C_MAGENTA = 12'hF0F;
    localparam rgb_t C_WHITE   = 12'hFFF;
    localparam rgb_t C_GREY    = 12'h888;

    function automatic int span4(input int a, input int b, input int c, input int d);
        return a + b + c + d;
    endfunction

endpackage

// File: rtl/vga_timing_gen.sv
// Line/frame counters for one pixel clock: sync levels, active window, active-area
// position and a registered frame-start pulse aligned with counter value (0,0).
module vga_timing_gen
    import vga_canvas_pkg::*;
#(
    parameter int H_SYNC = H_SYNC_DEF,
    parameter int H_BP   = H_BP_DEF,
    parameter int H_ACT  = H_ACT_DEF,
    parameter int H_FP   = H_FP_DEF,
    parameter int V_SYNC = V_SYNC_DEF,
    parameter int V_BP   = V_BP_DEF,
    parameter int V_ACT  = V_ACT_DEF,
    parameter int V_FP   = V_FP_DEF
) (
    input  logic        clkVga,
    input  logic        iRstN,
    output logic        active,
    output logic [10:0] h_pos,
    output logic [10:0] v_pos,
    output logic        hs_n,
    output logic        vs_n,
    output logic        frame
);

    localparam int HL  = span4(H_SYNC, H_BP, H_ACT, H_FP);
    localparam int VL  = span4(V_SYNC, V_BP, V_ACT, V_FP);
    localparam int HA0 = H_SYNC + H_BP;
    localparam int HA1 = HA0 + H_ACT;
    localparam int VA0 = V_SYNC + V_BP;
    localparam int VA1 = VA0 + V_ACT;

    logic [11:0] h_cnt;
    logic [11:0] v_cnt;
    logic        h_last;
    logic        v_last;

    assign h_last = (h_cnt == 12'(HL - 1));
    assign v_last = (v_cnt == 12'(VL - 1));

    // frame is registered from the wrap condition so it is high exactly while the counters read (0,0)
    always_ff @(posedge clkVga or negedge iRstN) begin
        if (!iRstN) begin
            h_cnt <= '0;
            v_cnt <= '0;
            frame <= 1'b0;
        end else begin
            h_cnt <= h_last ? 12'd0 : h_cnt + 12'd1;
            if (h_last) begin
                v_cnt <= v_last ? 12'd0 : v_cnt + 12'd1;
            end
            frame <= h_last && v_last;
        end
    end

    assign active = (h_cnt >= 12'(HA0)) && (h_cnt < 12'(HA1))
                 && (v_cnt >= 12'(VA0)) && (v_cnt < 12'(VA1));
    assign h_pos  = 11'(h_cnt - 12'(HA0));
    assign v_pos  = 11'(v_cnt - 12'(VA0));
    assign hs_n   = (h_cnt >= 12'(H_SYNC));
    assign vs_n   = (v_cnt >= 12'(V_SYNC));

endmodule

// File: rtl/vga_canvas_ctrl.sv
// VGA drawing canvas: GRID_N x GRID_N cell bitmap painted/erased from frame-latched
// cursor and buttons, sequenced column-wise clear, cursor overlay and registered RGB/sync.
module vga_canvas_ctrl
    import vga_canvas_pkg::*;
#(
    parameter int H_SYNC     = H_SYNC_DEF,
    parameter int H_BP       = H_BP_DEF,
    parameter int H_ACT      = H_ACT_DEF,
    parameter int H_FP       = H_FP_DEF,
    parameter int V_SYNC     = V_SYNC_DEF,
    parameter int V_BP       = V_BP_DEF,
    parameter int V_ACT      = V_ACT_DEF,
    parameter int V_FP       = V_FP_DEF,
    parameter int GRID_N     = 32,
    parameter int CELL_LOG2  = 4,
    parameter int CURSOR_SZ  = 8,
    parameter int BRUSH_PLUS = 0
) (
    input  logic                       clkVga,
    input  logic                       iRstN,
    input  logic                       iEna,
    input  logic [10:0]                iCurX,
    input  logic [10:0]                iCurY,
    input  logic [2:0]                 iBtn,
    input  logic                       iClear,
    output logic [3:0]                 oRed,
    output logic [3:0]                 oGreen,
    output logic [3:0]                 oBlue,
    output logic                       oHs,
    output logic                       oVs,
    output logic [GRID_N*GRID_N-1:0]   oImage,
    output logic                       oBusy,
    output logic                       oFrame,
    output canvas_state_e              dbg_state
);

    localparam int CW     = $clog2(GRID_N);
    localparam int CANVAS = GRID_N << CELL_LOG2;

    logic        active;
    logic [10:0] h_pos;
    logic [10:0] v_pos;
    logic        hs_n;
    logic        vs_n;
    logic        frame;

    vga_timing_gen #(
        .H_SYNC(H_SYNC), .H_BP(H_BP), .H_ACT(H_ACT), .H_FP(H_FP),
        .V_SYNC(V_SYNC), .V_BP(V_BP), .V_ACT(V_ACT), .V_FP(V_FP)
    ) u_timing (
        .clkVga(clkVga), .iRstN(iRstN), .active(active), .h_pos(h_pos),
        .v_pos(v_pos), .hs_n(hs_n), .vs_n(vs_n), .frame(frame)
    );

    assign oFrame = frame;

    logic [10:0] cur_x;
    logic [10:0] cur_y;
    logic [2:0]  btn;
    logic        frame_q;

    always_ff @(posedge clkVga or negedge iRstN) begin
        if (!iRstN) begin
            cur_x   <= '0;
            cur_y   <= '0;
            btn     <= '0;
            frame_q <= 1'b0;
        end else begin
            frame_q <= frame;
            if (frame) begin
                cur_x <= iCurX;
                cur_y <= iCurY;
                btn   <= iBtn;
            end
        end
    end

    logic [10:0] cell_x;
    logic [10:0] cell_y;
    logic        cell_valid;

    assign cell_x     = cur_x >> CELL_LOG2;
    assign cell_y     = cur_y >> CELL_LOG2;
    assign cell_valid = (cell_x < 11'(GRID_N)) && (cell_y < 11'(GRID_N));

    canvas_state_e   state;
    canvas_state_e   state_nxt;
    logic [CW-1:0]   col_idx;
    logic            wr_set;
    logic            wr_clr;
    logic            clr_col;

    always_ff @(posedge clkVga or negedge iRstN) begin
        if (!iRstN) state <= ST_IDLE;
        else        state <= state_nxt;
    end

    // A new frame_q is the only trigger for a write, so each frame requeues at most one stroke
    always_comb begin
        state_nxt = state;
        if (iClear) begin
            state_nxt = ST_CLEAR;
        end else begin
            unique case (state)
                ST_IDLE: begin
                    if (frame_q && btn[1])      state_nxt = ST_PAINT;
                    else if (frame_q && btn[0]) state_nxt = ST_ERASE;
                end
                ST_PAINT, ST_ERASE: state_nxt = ST_IDLE;
                ST_CLEAR: begin
                    if (col_idx == CW'(GRID_N - 1)) state_nxt = ST_IDLE;
                end
                default: state_nxt = ST_IDLE;
            endcase
        end
    end

    always_comb begin
        wr_set  = 1'b0;
        wr_clr  = 1'b0;
        clr_col = 1'b0;
        oBusy   = 1'b0;
        unique case (state)
            ST_PAINT: wr_set = iEna && cell_valid;
            ST_ERASE: wr_clr = iEna && cell_valid;
            ST_CLEAR: begin
                clr_col = 1'b1;
                oBusy   = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clkVga or negedge iRstN) begin
        if (!iRstN)                      col_idx <= '0;
        else if (iClear)                 col_idx <= '0;
        else if (state == ST_CLEAR)      col_idx <= col_idx + 1'b1;
    end

    assign dbg_state = state;

    // Brush and clear-column masks; grid bounds come from the loop range, so edges never wrap
    logic [GRID_N*GRID_N-1:0] brush_mask;
    logic [GRID_N*GRID_N-1:0] col_mask;

    for (genvar gx = 0; gx < GRID_N; gx++) begin : g_x
        for (genvar gy = 0; gy < GRID_N; gy++) begin : g_y
            logic hit;
            logic nbr;
            assign hit = (cell_x == 11'(gx)) && (cell_y == 11'(gy));
            assign nbr = ((cell_x == 11'(gx)) && ((cell_y + 11'd1 == 11'(gy)) || (cell_y == 11'(gy + 1))))
                      || ((cell_y == 11'(gy)) && ((cell_x + 11'd1 == 11'(gx)) || (cell_x == 11'(gx + 1))));
            assign brush_mask[gx*GRID_N+gy] = cell_valid && (hit || ((BRUSH_PLUS != 0) && nbr));
            assign col_mask[gx*GRID_N+gy]   = (col_idx == CW'(gx));
        end
    end

    always_ff @(posedge clkVga or negedge iRstN) begin
        if (!iRstN)      oImage <= '0;
        else if (clr_col) oImage <= oImage & ~col_mask;
        else if (wr_set)  oImage <= oImage | brush_mask;
        else if (wr_clr)  oImage <= oImage & ~brush_mask;
    end

    logic [CW-1:0] px_cx;
    logic [CW-1:0] px_cy;
    logic          in_canvas;
    logic          in_cur;
    rgb_t          pix;

    assign px_cx     = h_pos[CELL_LOG2 +: CW];
    assign px_cy     = v_pos[CELL_LOG2 +: CW];
    assign in_canvas = (h_pos < 11'(CANVAS)) && (v_pos < 11'(CANVAS));
    assign in_cur    = ({1'b0, h_pos} >= {1'b0, cur_x}) && ({1'b0, h_pos} < {1'b0, cur_x} + 12'(CURSOR_SZ))
                    && ({1'b0, v_pos} >= {1'b0, cur_y}) && ({1'b0, v_pos} < {1'b0, cur_y} + 12'(CURSOR_SZ));

    always_comb begin
        pix = C_BLANK;
        if (active && iEna) begin
            if (in_cur) begin
                if (btn[2])      pix = C_GREEN;
                else if (btn[1]) pix = C_BLUE;
                else if (btn[0]) pix = C_YELLOW;
                else             pix = C_RED;
            end else if (in_canvas) begin
                pix = oImage[{px_cx, px_cy}] ? C_MAGENTA : C_WHITE;
            end else begin
                pix = C_GREY;
            end
        end
    end

    always_ff @(posedge clkVga or negedge iRstN) begin
        if (!iRstN) begin
            {oRed, oGreen, oBlue} <= '0;
            oHs                   <= 1'b0;
            oVs                   <= 1'b0;
        end else begin
            {oRed, oGreen, oBlue} <= pix;
            oHs                   <= hs_n;
            oVs                   <= vs_n;
        end
    end

endmodule
